pdp8_sram_ctl: RTL and testbench

Responder for the CPU's memory port on the FPGA board: accepts a read or write request on the 15-bit word address / 12-bit data interface and executes it against the external asynchronous 16-bit SRAM (bank 1). It sits between `pdp8` and the `ram_a` / `ram_oe_n` / `ram_we_n` / `ram1_*` pins at top level, as the off-chip replacement for the on-chip `pdp8_ram`. Each access runs a timed strobe sequence and reports completion with a one-cycle `done` pulse.

---
 rtl/pdp8_sram_ctl_pkg.sv | 21 ++
 rtl/pdp8_sram_ctl_if.sv | 23 ++
 rtl/pdp8_sram_ctl.sv | 159 +++++++++++++++
 tb/tb_pdp8_sram_ctl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp8_sram_ctl_pkg.sv
// pdp8_sram_ctl shared definitions: FSM state encodings, default strobe width
// and the word parity helper used when PDP8_SRAM_PARITY_EN is defined.
package pdp8_sram_ctl_pkg;

  // Default OE/WE strobe width in clk cycles (minimum 1).
  localparam int WAIT_CYCLES_DEF = 2;

  // 3-bit state encodings, kept as plain constants for legacy compatibility.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RSTB  = 3'd1;
  localparam logic [2:0] ST_RDONE = 3'd2;
  localparam logic [2:0] ST_WSET  = 3'd3;
  localparam logic [2:0] ST_WSTB  = 3'd4;
  localparam logic [2:0] ST_WHLD  = 3'd5;

  // Even parity bit over a 12-bit PDP-8 word (bit 12 makes 13 bits even).
  function automatic logic word_par(input logic [11:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/pdp8_sram_ctl_if.sv
// CPU-side memory port of pdp8_sram_ctl: 15-bit word address, 12-bit data,
// level rd/wr requests, busy/done status and the sticky parity error flag.
// master = the pdp8 CPU, slave = the SRAM controller.
interface pdp8_sram_ctl_if;
  logic [14:0] addr;
  logic [11:0] data_in;
  logic [11:0] data_out;
  logic        rd;
  logic        wr;
  logic        busy;
  logic        done;
  logic        parity_err;

  modport master (
    output addr, data_in, rd, wr,
    input  data_out, busy, done, parity_err
  );

  modport slave (
    input  addr, data_in, rd, wr,
    output data_out, busy, done, parity_err
  );
endinterface

// File: rtl/pdp8_sram_ctl.sv
// Purpose: PDP-8 memory port responder driving the external async 16-bit SRAM (bank 1).
// Latency: read done in cycle WAIT_CYCLES+1, write done in cycle WAIT_CYCLES+2 after acceptance.
// Backpressure: one access per request assertion; requests outside IDLE are ignored (busy high).
// Optional feature: define PDP8_SRAM_PARITY_EN for even parity on ram1_io[12].
module pdp8_sram_ctl
  import pdp8_sram_ctl_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  pdp8_sram_ctl_if.slave     cpu,
  output logic [17:0]        ram_a,
  output logic               ram_oe_n,
  output logic               ram_we_n,
  inout  wire  [15:0]        ram1_io,
  output logic               ram1_ce_n,
  output logic               ram1_ub_n,
  output logic               ram1_lb_n,
  output logic               ram2_ce_n
);

  localparam int              CW       = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(WAIT_CYCLES);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic          req_q;
  logic [14:0]   addr_q;
  logic [11:0]   wdata_q;
  logic [11:0]   rdata_q;
  logic          accept;
  logic          last_stb;
  logic          capture;
  logic          ce_n_q;
  logic          oe_n_q;
  logic          we_n_q;
  logic          drive_q;
  logic          done_q;
  logic          busy_q;
  logic          par_w;
  logic          unused_bus;

  // Edge-qualified acceptance: a level request only starts one access.
  assign accept   = (state == ST_IDLE) && (cpu.rd || cpu.wr) && !req_q;
  assign last_stb = (cnt == CNT_ONE);
  assign capture  = (state == ST_RSTB) && last_stb;

  // Next-state logic; a write wins over a simultaneous read.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = cpu.wr ? ST_WSET : ST_RSTB;
      ST_RSTB:  if (last_stb) state_nxt = ST_RDONE;
      ST_RDONE: state_nxt = ST_IDLE;
      ST_WSET:  state_nxt = ST_WSTB;
      ST_WSTB:  if (last_stb) state_nxt = ST_WHLD;
      ST_WHLD:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register, request history and strobe-width timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      req_q <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      req_q <= cpu.rd || cpu.wr;
      if ((state_nxt == ST_RSTB && state != ST_RSTB) ||
          (state_nxt == ST_WSTB && state != ST_WSTB))
        cnt <= CNT_LOAD;
      else if (cnt != '0)
        cnt <= cnt - CNT_ONE;
    end
  end

  // Address and write data are frozen at acceptance for the whole access.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= cpu.addr;
      wdata_q <= cpu.data_in;
    end
  end

  // Read data is sampled on the last edge of the OE strobe and then held.
  always_ff @(posedge clk) begin
    if (reset)
      rdata_q <= '0;
    else if (capture)
      rdata_q <= ram1_io[11:0];
  end

  // Pin strobes and status are registered from the next state so the SRAM
  // sees glitch-free levels that line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      drive_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ce_n_q  <= !(state_nxt == ST_RSTB || state_nxt == ST_WSET ||
                   state_nxt == ST_WSTB || state_nxt == ST_WHLD);
      oe_n_q  <= !(state_nxt == ST_RSTB);
      we_n_q  <= !(state_nxt == ST_WSTB);
      drive_q <= (state_nxt == ST_WSET || state_nxt == ST_WSTB ||
                  state_nxt == ST_WHLD);
      done_q  <= (state_nxt == ST_RDONE || state_nxt == ST_WHLD);
      busy_q  <= (state_nxt != ST_IDLE);
    end
  end

`ifdef PDP8_SRAM_PARITY_EN
  logic perr_q;

  assign par_w = word_par(wdata_q);

  // Sticky parity error, only cleared by reset.
  always_ff @(posedge clk) begin
    if (reset)
      perr_q <= 1'b0;
    else if (capture && (ram1_io[12] != word_par(ram1_io[11:0])))
      perr_q <= 1'b1;
  end

  assign cpu.parity_err = perr_q;
  assign unused_bus     = ^ram1_io[15:13];
`else
  assign par_w          = 1'b0;
  assign cpu.parity_err = 1'b0;
  assign unused_bus     = ^ram1_io[15:12];
`endif

  // Bus is only driven across the WSET..WHLD window.
  assign ram1_io = drive_q ? {3'b000, par_w, wdata_q} : 16'hzzzz;

  assign ram_a        = {3'b000, addr_q};
  assign ram_oe_n     = oe_n_q;
  assign ram_we_n     = we_n_q;
  assign ram1_ce_n    = ce_n_q;
  assign ram1_ub_n    = ce_n_q;
  assign ram1_lb_n    = ce_n_q;
  assign ram2_ce_n    = 1'b1;

  assign cpu.data_out = rdata_q;
  assign cpu.done     = done_q;
  assign cpu.busy     = busy_q;

endmodule

// File: tb/tb_pdp8_sram_ctl.sv
// Bench for pdp8_sram_ctl: SRAM model, table-driven accesses with a read-data
// scoreboard, plus reset-mid-write, held request, parity and strobe-width sweep.
module tb_pdp8_sram_ctl;

`ifdef PDP8_SRAM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Main DUT, WAIT_CYCLES = 2
  pdp8_sram_ctl_if cpu();
  wire [17:0] ram_a;
  wire        ram_oe_n, ram_we_n, ram1_ce_n, ram1_ub_n, ram1_lb_n, ram2_ce_n;
  wire [15:0] ram1_io;

  pdp8_sram_ctl #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .cpu(cpu),
    .ram_a(ram_a), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .ram1_io(ram1_io),
    .ram1_ce_n(ram1_ce_n), .ram1_ub_n(ram1_ub_n), .ram1_lb_n(ram1_lb_n),
    .ram2_ce_n(ram2_ce_n)
  );

  // SRAM model
  logic [15:0] mem [0:32767];
  logic        bad_par;
  logic        probe_en;
  logic [15:0] probe_val;

  always @(posedge clk)
    if (!ram1_ce_n && !ram_we_n) mem[ram_a[14:0]] <= ram1_io;

  assign ram1_io = (!ram_oe_n && !ram1_ce_n) ? (bad_par ? 16'h1000 : mem[ram_a[14:0]])
                 : (probe_en ? probe_val : 16'hzzzz);

  // Sweep DUTs, WAIT_CYCLES = 1 and 5, read-only model returning 0x0ABC
  pdp8_sram_ctl_if cpu1();
  pdp8_sram_ctl_if cpu5();
  logic       sw_rd [2];
  wire [17:0] sw_unused_a1, sw_unused_a5;
  wire        oe1, oe5, ce1, ce5;
  wire        sw_unused_we1, sw_unused_we5, sw_unused_ub1, sw_unused_ub5;
  wire        sw_unused_lb1, sw_unused_lb5, sw_unused_c21, sw_unused_c25;
  wire [15:0] io1, io5;

  assign cpu1.rd = sw_rd[0];
  assign cpu1.wr = 1'b0;
  assign cpu1.addr = 15'd0;
  assign cpu1.data_in = 12'd0;
  assign cpu5.rd = sw_rd[1];
  assign cpu5.wr = 1'b0;
  assign cpu5.addr = 15'd0;
  assign cpu5.data_in = 12'd0;
  assign io1 = (!oe1 && !ce1) ? 16'h0ABC : 16'hzzzz;
  assign io5 = (!oe5 && !ce5) ? 16'h0ABC : 16'hzzzz;

  pdp8_sram_ctl #(.WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .reset(reset), .cpu(cpu1),
    .ram_a(sw_unused_a1), .ram_oe_n(oe1), .ram_we_n(sw_unused_we1), .ram1_io(io1),
    .ram1_ce_n(ce1), .ram1_ub_n(sw_unused_ub1), .ram1_lb_n(sw_unused_lb1),
    .ram2_ce_n(sw_unused_c21)
  );

  pdp8_sram_ctl #(.WAIT_CYCLES(5)) dut_w5 (
    .clk(clk), .reset(reset), .cpu(cpu5),
    .ram_a(sw_unused_a5), .ram_oe_n(oe5), .ram_we_n(sw_unused_we5), .ram1_io(io5),
    .ram1_ce_n(ce5), .ram1_ub_n(sw_unused_ub5), .ram1_lb_n(sw_unused_lb5),
    .ram2_ce_n(sw_unused_c25)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: one entry per expected done pulse on the main DUT
  typedef struct {
    logic        is_rd;
    logic [11:0] data;
  } sb_t;
  sb_t sbq [$];

  always @(negedge clk) begin
    sb_t e;
    if (cpu.done) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        e = sbq.pop_front();
        if (e.is_rd) check("read_data", {20'd0, cpu.data_out}, {20'd0, e.data});
      end
    end
  end

  task automatic push_sb(input logic is_rd, input logic [11:0] d);
    sb_t e;
    e.is_rd = is_rd;
    e.data  = d;
    sbq.push_back(e);
  endtask

  // One access on the main DUT: measures done cycle and strobe widths
  task automatic run_access(input logic w, input logic r, input logic [14:0] a,
                            input logic [11:0] d, output int done_k,
                            output int we_k, output int oe_k);
    int t0;
    @(negedge clk);
    cpu.wr = w; cpu.rd = r; cpu.addr = a; cpu.data_in = d;
    t0 = cyc + 1;
    done_k = -1; we_k = 0; oe_k = 0;
    for (int i = 0; i < 40 && done_k < 0; i++) begin
      @(negedge clk);
      if (!ram_we_n) we_k++;
      if (!ram_oe_n) oe_k++;
      if (cpu.done) done_k = cyc - t0 + 1;
    end
    cpu.wr = 1'b0; cpu.rd = 1'b0;
    @(negedge clk);
    check("busy_after_access", {31'd0, cpu.busy}, 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [14:0] addr;
    logic [11:0] din;
    int          exp_done;
    int          exp_we;
    int          exp_oe;
    logic [11:0] exp_dout;
  } vec_t;

  initial begin
    vec_t        vecs [8];
    int          dk, wk, ok, base, t0;
    logic [11:0] pw;
    logic [15:0] exp_word;

    vecs[0] = '{1'b1, 1'b0, 15'o01234, 12'o7301, 4, 2, 0, 12'o0000};
    vecs[1] = '{1'b0, 1'b1, 15'o01234, 12'o0000, 3, 0, 2, 12'o7301};
    vecs[2] = '{1'b1, 1'b0, 15'o77777, 12'o7777, 4, 2, 0, 12'o0000};
    vecs[3] = '{1'b1, 1'b0, 15'o00000, 12'o0000, 4, 2, 0, 12'o0000};
    vecs[4] = '{1'b0, 1'b1, 15'o77777, 12'o0000, 3, 0, 2, 12'o7777};
    vecs[5] = '{1'b0, 1'b1, 15'o00000, 12'o0000, 3, 0, 2, 12'o0000};
    vecs[6] = '{1'b1, 1'b1, 15'o00100, 12'o1234, 4, 2, 0, 12'o0000};
    vecs[7] = '{1'b0, 1'b1, 15'o00100, 12'o0000, 3, 0, 2, 12'o1234};

    reset = 1'b1; bad_par = 1'b0; probe_en = 1'b0; probe_val = 16'h0;
    cpu.rd = 1'b0; cpu.wr = 1'b0; cpu.addr = 15'd0; cpu.data_in = 12'd0;
    sw_rd[0] = 1'b0; sw_rd[1] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_done",     {31'd0, cpu.done},       32'd0);
    check("rst_busy",     {31'd0, cpu.busy},       32'd0);
    check("rst_perr",     {31'd0, cpu.parity_err}, 32'd0);
    check("rst_data_out", {20'd0, cpu.data_out},   32'd0);
    check("rst_ram_a",    {14'd0, ram_a},          32'd0);
    check("rst_strobes",  {26'd0, ram_oe_n, ram_we_n, ram1_ce_n, ram1_ub_n, ram1_lb_n, ram2_ce_n},
          32'h3F);
    probe_en = 1'b1; probe_val = 16'h5A3C;
    #1 check("rst_bus_released", {16'd0, ram1_io}, 32'h5A3C);
    probe_en = 1'b0;

    // Table-driven accesses
    for (int i = 0; i < 8; i++) begin
      push_sb(vecs[i].rd && !vecs[i].wr, vecs[i].exp_dout);
      run_access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].din, dk, wk, ok);
      check($sformatf("vec%0d_done_cycle", i), dk, vecs[i].exp_done);
      check($sformatf("vec%0d_we_width", i), wk, vecs[i].exp_we);
      check($sformatf("vec%0d_oe_width", i), ok, vecs[i].exp_oe);
    end

    // Stored word including bit 12 (parity or zero)
    pw = 12'o1234;
    exp_word = {3'b000, PAR_EN & (^pw), pw};
    check("stored_word_bit12", {16'd0, mem[15'o00100]}, {16'd0, exp_word});

    // Reset during WSTB: strobes released, no done
    base = done_cnt;
    @(negedge clk);
    cpu.wr = 1'b1; cpu.addr = 15'o00200; cpu.data_in = 12'o4321;
    for (int i = 0; i < 10 && ram_we_n; i++) @(negedge clk);
    check("mid_wr_we_low", {31'd0, ram_we_n}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_we_n",  {31'd0, ram_we_n},  32'd1);
    check("mid_rst_ce_n",  {31'd0, ram1_ce_n}, 32'd1);
    check("mid_rst_busy",  {31'd0, cpu.busy},  32'd0);
    probe_en = 1'b1; probe_val = 16'hC3A5;
    #1 check("mid_rst_bus_released", {16'd0, ram1_io}, 32'hC3A5);
    probe_en = 1'b0;
    @(negedge clk);
    reset = 1'b0; cpu.wr = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_rst_no_done", done_cnt - base, 0);

    // Held read request: exactly one access, then re-arm after a 1-cycle drop
    base = done_cnt;
    push_sb(1'b1, 12'o7301);
    cpu.addr = 15'o01234; cpu.rd = 1'b1;
    repeat (20) @(negedge clk);
    check("held_rd_one_done", done_cnt - base, 1);
    cpu.rd = 1'b0;
    @(negedge clk);
    push_sb(1'b1, 12'o7301);
    cpu.rd = 1'b1;
    repeat (10) @(negedge clk);
    check("held_rd_rearm", done_cnt - base, 2);
    cpu.rd = 1'b0;
    repeat (2) @(negedge clk);

    // Parity: bad word sets sticky flag (only with the feature built in)
    bad_par = 1'b1;
    push_sb(1'b1, 12'h000);
    run_access(1'b0, 1'b1, 15'o01234, 12'd0, dk, wk, ok);
    check("perr_after_bad", {31'd0, cpu.parity_err}, {31'd0, PAR_EN});
    bad_par = 1'b0;
    push_sb(1'b1, 12'o7301);
    run_access(1'b0, 1'b1, 15'o01234, 12'd0, dk, wk, ok);
    check("perr_sticky", {31'd0, cpu.parity_err}, {31'd0, PAR_EN});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("perr_cleared", {31'd0, cpu.parity_err}, 32'd0);

    // Strobe-width sweep on WAIT_CYCLES = 1 and 5
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      sw_rd[s] = 1'b1;
      t0 = cyc + 1;
      dk = -1; ok = 0;
      for (int i = 0; i < 40 && dk < 0; i++) begin
        @(negedge clk);
        if (!((s == 0) ? oe1 : oe5)) ok++;
        if ((s == 0) ? cpu1.done : cpu5.done) dk = cyc - t0 + 1;
      end
      sw_rd[s] = 1'b0;
      check($sformatf("sweep%0d_done_cycle", s), dk, (s == 0) ? 2 : 6);
      check($sformatf("sweep%0d_oe_width", s), ok, (s == 0) ? 1 : 5);
      check($sformatf("sweep%0d_data", s),
            {20'd0, (s == 0) ? cpu1.data_out : cpu5.data_out}, 32'h0ABC);
      @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
